// File: rtl/ac_pkg.sv
// Shared types and header-layout constants for the arithmetic-coder frame sequencer.
package ac_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_FINISH,
        S_READ,
        S_DONE
    } ac_state_t;

    localparam int ERR_OVF         = 0;
    localparam int ERR_TMO         = 1;
    localparam int HDR_ENTRY_BYTES = 3;
    localparam int HDR_LEN_BYTES   = 2;
    localparam int TOTAL_W         = 17;

    // Index of the length high byte: 1 + 3*E, with E = count_byte + 1.
    function automatic logic [9:0] len_hi_index(input logic [7:0] count_byte);
        return 10'(HDR_ENTRY_BYTES) * ({2'b00, count_byte} + 10'd1) + 10'd1;
    endfunction

endpackage

// File: rtl/ac_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module ac_sdp_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) r_rdata <= '0;
        else     r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ac_frame_sequencer.sv
// Frames one arithmetic_coder encode run: feed buffered symbols, drain, then capture
// the compressed stream up to the length announced in its own header.
module ac_frame_sequencer
    import ac_pkg::*;
#(
    parameter int SYMBOL_W       = 8,
    parameter int DATA_W         = 8,
    parameter int NUM_SYMBOLS    = 128,
    parameter int OUT_DEPTH      = 256,
    parameter int DRAIN_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SYMBOL_W-1:0]          load_symbol_in,
    input  logic                         load_valid_in,
    output logic                         load_ready_out,
    input  logic                         start_in,
    output logic [SYMBOL_W-1:0]          coder_symbol_out,
    output logic                         coder_valid_out,
    output logic                         coder_wr_complete_out,
    output logic                         coder_next_out,
    input  logic [DATA_W-1:0]            coder_data_in,
    input  logic                         coder_valid_in,
    input  logic [$clog2(OUT_DEPTH)-1:0] rd_addr_in,
    output logic [DATA_W-1:0]            rd_data_out,
    output logic [$clog2(NUM_SYMBOLS):0] sym_count_out,
    output logic [$clog2(OUT_DEPTH):0]   out_count_out,
    output logic                         done_out,
    output logic [1:0]                   error_out
);

    localparam int SAW   = $clog2(NUM_SYMBOLS);
    localparam int OAW   = $clog2(OUT_DEPTH);
    localparam int CNT_W = $clog2((DRAIN_CYCLES > TIMEOUT_CYCLES ? DRAIN_CYCLES : TIMEOUT_CYCLES) + 1);

    ac_state_t            r_state, w_next;
    logic [SAW:0]         r_sym_count;
    logic [SAW-1:0]       r_feed_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic [OAW:0]         r_out_count;
    logic [9:0]           r_len_idx;
    logic [7:0]           r_len_hi;
    logic [TOTAL_W-1:0]   r_total;
    logic                 r_total_ok;
    logic                 r_done;
    logic [1:0]           r_err;

    logic [SYMBOL_W-1:0]  w_sym_rdata;
    logic [SAW-1:0]       w_sym_raddr;
    logic [7:0]           w_byte;
    logic                 w_load, w_full, w_feed_last, w_accept, w_ovf, w_cnt_tmo, w_tmo_err;
    logic                 w_is_hi, w_is_lo, w_last;
    logic [TOTAL_W-1:0]   w_oc_next, w_total_now;

    assign w_byte      = coder_data_in[7:0];
    assign w_full      = (r_sym_count == (SAW+1)'(NUM_SYMBOLS));
    assign w_load      = (r_state == S_IDLE) && load_valid_in && !w_full && !start_in;
    assign w_feed_last = ({1'b0, r_feed_idx} == r_sym_count - (SAW+1)'(1));
    assign w_accept    = (r_state == S_READ) && coder_valid_in;
    assign w_ovf       = (r_out_count == (OAW+1)'(OUT_DEPTH));
    assign w_cnt_tmo   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_tmo_err   = ((r_state == S_FINISH) || (r_state == S_READ)) && !coder_valid_in && w_cnt_tmo;

    // The read is issued one cycle ahead so symbol k is on the RAM output in FEED cycle k.
    assign w_sym_raddr = (r_state == S_FEED) ? r_feed_idx + SAW'(1) : '0;

    assign w_oc_next   = TOTAL_W'(r_out_count) + TOTAL_W'(1);
    assign w_is_hi     = (r_out_count != '0) && (TOTAL_W'(r_out_count) == TOTAL_W'(r_len_idx));
    assign w_is_lo     = (r_out_count != '0) && (TOTAL_W'(r_out_count) == TOTAL_W'(r_len_idx) + TOTAL_W'(1));
    assign w_total_now = TOTAL_W'(r_len_idx) + TOTAL_W'(HDR_LEN_BYTES) + TOTAL_W'({r_len_hi, w_byte});
    assign w_last      = w_is_lo ? (w_oc_next == w_total_now) : (r_total_ok && (w_oc_next == r_total));

    always_comb begin
        w_next                = r_state;
        load_ready_out        = 1'b0;
        coder_valid_out       = 1'b0;
        coder_wr_complete_out = 1'b0;
        coder_next_out        = 1'b0;
        case (r_state)
            S_IDLE: begin
                load_ready_out = !w_full;
                if (start_in) w_next = (r_sym_count == '0) ? S_DONE : S_FEED;
            end
            S_FEED: begin
                coder_valid_out = 1'b1;
                if (w_feed_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_cnt == CNT_W'(DRAIN_CYCLES - 1)) w_next = S_FINISH;
            end
            S_FINISH: begin
                coder_wr_complete_out = 1'b1;
                if (coder_valid_in) w_next = S_READ;
                else if (w_cnt_tmo) w_next = S_DONE;
            end
            S_READ: begin
                coder_wr_complete_out = 1'b1;
                coder_next_out        = 1'b1;
                if (w_accept) begin
                    if (w_ovf || w_last) w_next = S_DONE;
                end else if (w_cnt_tmo) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sym_count <= '0;
            r_feed_idx  <= '0;
            r_cnt       <= '0;
            r_out_count <= '0;
            r_len_idx   <= '0;
            r_len_hi    <= '0;
            r_total     <= '0;
            r_total_ok  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= '0;
        end else begin
            r_state <= w_next;
            // One counter serves drain length, valid wait and inter-byte gap.
            r_cnt   <= ((w_next != r_state) || w_accept) ? '0 : r_cnt + CNT_W'(1);
            if (w_load) r_sym_count <= r_sym_count + (SAW+1)'(1);
            if (r_state == S_FEED) r_feed_idx <= r_feed_idx + SAW'(1);
            if ((r_state == S_IDLE) && start_in) begin
                r_done      <= 1'b0;
                r_err       <= '0;
                r_out_count <= '0;
                r_feed_idx  <= '0;
                r_total_ok  <= 1'b0;
            end
            if (w_accept && w_ovf) r_err[ERR_OVF] <= 1'b1;
            if (w_accept && !w_ovf) begin
                r_out_count <= r_out_count + (OAW+1)'(1);
                if (r_out_count == '0) r_len_idx <= len_hi_index(w_byte);
                if (w_is_hi) r_len_hi <= w_byte;
                if (w_is_lo) begin
                    r_total    <= w_total_now;
                    r_total_ok <= 1'b1;
                end
            end
            if (w_tmo_err) r_err[ERR_TMO] <= 1'b1;
            if (w_next == S_DONE) r_done <= 1'b1;
        end
    end

    ac_sdp_ram #(.WIDTH(SYMBOL_W), .DEPTH(NUM_SYMBOLS)) u_sym_buf (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_load),
        .i_waddr (r_sym_count[SAW-1:0]),
        .i_wdata (load_symbol_in),
        .i_raddr (w_sym_raddr),
        .o_rdata (w_sym_rdata)
    );

    ac_sdp_ram #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_cap_buf (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_accept && !w_ovf),
        .i_waddr (r_out_count[OAW-1:0]),
        .i_wdata (coder_data_in),
        .i_raddr (rd_addr_in),
        .o_rdata (rd_data_out)
    );

    assign coder_symbol_out = coder_valid_out ? w_sym_rdata : '0;
    assign sym_count_out    = r_sym_count;
    assign out_count_out    = r_out_count;
    assign done_out         = r_done;
    assign error_out        = r_err;

endmodule

// File: doc/ac_frame_sequencer.md
Name: ac_frame_sequencer

Overview:
- Synthesizable on-chip sequencer that frames one complete encode run of arithmetic_coder.
- It buffers a message of symbols and streams them into the coder at one per cycle. After the message it waits a programmable drain interval, then asserts wr_complete.
- It reads back the compressed stream, parsing the header (table-entry count, three bytes per entry, 16-bit big-endian payload length) so that it stops at the true end of stream rather than after a fixed byte count.
- It sits between a host/load port and arithmetic_coder, and is parametrised in symbol width, depths, drain and timeout.

Parameters:
- SYMBOL_W, 8, symbol width in bits.
- DATA_W, 8, coder output byte width in bits. The header parse requires DATA_W = 8.
- NUM_SYMBOLS, 128, symbol buffer depth; power of two.
- OUT_DEPTH, 256, capture buffer depth in bytes; power of two.
- DRAIN_CYCLES, 50, idle cycles between the last symbol and wr_complete assertion.
- TIMEOUT_CYCLES, 4096, maximum wait for coder valid after wr_complete, and maximum gap between accepted bytes in READ.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- load_symbol_in  in  SYMBOL_W  symbol to buffer.
- load_valid_in  in  1  load strobe.
- load_ready_out  out  1  high in IDLE when the buffer is not full.
- start_in  in  1  begin run (IDLE only).
- coder_symbol_out  out  SYMBOL_W  to arithmetic_coder symbol_in.
- coder_valid_out  out  1  to valid_in.
- coder_wr_complete_out  out  1  to wr_complete_in.
- coder_next_out  out  1  to next_in.
- coder_data_in  in  DATA_W  from data_out.
- coder_valid_in  in  1  from valid_out.
- rd_addr_in  in  $clog2(OUT_DEPTH)  capture buffer read address.
- rd_data_out  out  DATA_W  captured byte, one-cycle read latency.
- sym_count_out  out  $clog2(NUM_SYMBOLS)+1  symbols loaded.
- out_count_out  out  $clog2(OUT_DEPTH)+1  bytes captured.
- done_out  out  1  run finished (sticky until start_in or rst).
- error_out  out  2  bit0 = capture overflow, bit1 = timeout; sticky.

Behaviour:
- Reset: state IDLE; all outputs 0 except load_ready_out = 1; counters cleared. Buffer contents are undefined.
- Reset mid-run: the run is abandoned, the coder outputs drop to 0 on the next edge, and the coder is not otherwise notified.
- IDLE:
  - load_valid_in && load_ready_out writes the symbol at sym_count and increments sym_count.
  - Loads are ignored when the buffer is full (sym_count = NUM_SYMBOLS).
  - start_in with sym_count = 0 sets done_out immediately, with out_count = 0; no coder activity.
  - start_in with sym_count > 0 clears done/error/out_count and goes to FEED. start_in takes priority over a same-cycle load, which is dropped.
- FEED: coder_valid_out = 1 for exactly sym_count consecutive cycles, presenting symbols 0..sym_count-1 in order. The first symbol appears the cycle after start_in. Then go to DRAIN.
- DRAIN: coder outputs 0 for DRAIN_CYCLES cycles, then go to FINISH.
- FINISH:
  - coder_wr_complete_out = 1, held high through READ until DONE.
  - Wait for coder_valid_in; when it is seen, go to READ.
  - If TIMEOUT_CYCLES elapse first, set error bit1 and go to DONE.
- READ:
  - coder_next_out = 1.
  - A byte is accepted in a cycle where coder_next_out && coder_valid_in. It is written to capture[out_count] and out_count increments.
  - Parse on accepted bytes: byte0 gives E = byte0+1; total = 1 + 3E + 2 + L, where L = {byte(3E+1), byte(3E+2)}.
  - Go to DONE on the accept that makes out_count = total.
  - If a byte is accepted with out_count = OUT_DEPTH: set error bit0, discard the byte, go to DONE.
  - If the gap between accepts exceeds TIMEOUT_CYCLES: set error bit1, go to DONE.
- DONE:
  - All coder outputs are 0 and done_out = 1.
  - Return to IDLE on the same cycle; sym_count is retained so the same message can be rerun with start_in.
- Capture buffer read port:
  - Readable in every state.
  - Registered output: rd_data_out is valid one cycle after rd_addr_in.
  - Reads beyond out_count return stale data.

Decomposition:
- Package ac_pkg: state enum (IDLE, FEED, DRAIN, FINISH, READ, DONE), error bit indices, header-field offset constants.
- One sub-module, ac_sdp_ram: parametrised simple dual-port RAM (width, depth) with registered read.
- ac_sdp_ram is instantiated twice: symbol buffer and capture buffer.

Test Plan:
- Load 98 ASCII bytes, start, behavioural coder model → coder_valid_out high for exactly 98 cycles in order, wr_complete rises 50 cycles after the last symbol, out_count matches 1+3E+2+L from the model, done_out = 1, error_out = 0.
- Model header E = 1, L = 3 → exactly 9 bytes captured, and coder_next_out drops the cycle after the 9th accept.
- Coder model deasserts coder_valid_in for 10 cycles mid-READ → no bytes lost; capture contents identical to the no-stall run.
- OUT_DEPTH = 16 with model total = 20 → 16 bytes stored, error_out = 01, done_out = 1.
- Coder model never asserts valid, TIMEOUT_CYCLES = 64 → error_out = 10, done 64 cycles after wr_complete rises.
- rst asserted on the 5th FEED cycle → next cycle all coder outputs 0, load_ready_out = 1, sym_count = 0; start_in with an empty buffer → done_out = 1, out_count = 0.
